// File: rtl/pix_collect_if.sv
// Pixel-in / byte-out bundle for pix_collect: pixel stream, host handshake and status flags.
interface pix_collect_if;
    logic       pix;
    logic       pvalid;
    logic       rdy;
    logic [7:0] data;
    logic       dvalid;
    logic       line_done;
    logic       frame_done;
    logic       overflow;

    modport master (
        output pix, pvalid, rdy,
        input  data, dvalid, line_done, frame_done, overflow
    );

    modport slave (
        input  pix, pvalid, rdy,
        output data, dvalid, line_done, frame_done, overflow
    );
endinterface

// File: rtl/pix_collect.sv
// Packs the 1-bit morphology output MSB-first into bytes, queues them in a
// small FIFO for the host, and tracks raster position for line/frame pulses.
module pix_collect #(
    parameter int W     = 256,
    parameter int H     = 256,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    pix_collect_if.slave bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
    localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

    logic [7:0]    sh;
    logic [2:0]    bit_cnt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [AW:0]   count;
    logic [AW:0]   count_next;

    logic [7:0]    byte_in;
    logic [7:0]    head_next;
    logic          push;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          drop;
    logic          col_last;
    logic          row_last;

    // Next-state decode for the packer and FIFO; the head byte is precomputed
    // so data can be registered while still tracking the FIFO head exactly.
    always_comb begin
        byte_in    = {sh[6:0], bus.pix};
        push       = bus.pvalid && (bit_cnt == 3'd7);
        pop        = bus.dvalid && bus.rdy;
        full       = (count == FULL);
        push_ok    = push && (!full || pop);
        drop       = push && full && !pop;
        rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_next = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
        // A push landing in the slot that becomes head (empty, or last entry popped)
        head_next  = (push_ok && (wr_ptr == rd_next)) ? byte_in : mem[rd_next];
        col_last   = (col == COL_LAST);
        row_last   = (row == ROW_LAST);
    end

    // FIFO storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= byte_in;
        end
    end

    // Packer, raster counters, FIFO pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh             <= '0;
            bit_cnt        <= '0;
            col            <= '0;
            row            <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            bus.data       <= 8'h00;
            bus.dvalid     <= 1'b0;
            bus.line_done  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.overflow   <= 1'b0;
        end else begin
            bus.line_done  <= 1'b0;
            bus.frame_done <= 1'b0;
            if (bus.pvalid) begin
                sh      <= byte_in;
                bit_cnt <= bit_cnt + 3'd1;
                if (col_last) begin
                    col           <= '0;
                    bus.line_done <= 1'b1;
                    if (row_last) begin
                        row            <= '0;
                        bus.frame_done <= 1'b1;
                    end else begin
                        row <= row + RW'(1);
                    end
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_next;
            count      <= count_next;
            bus.dvalid <= (count_next != '0);
            if (count_next != '0) begin
                bus.data <= head_next;
            end
            if (drop) begin
                bus.overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pix_collect.sv
// Randomized bench for pix_collect against a queue-based reference model.
module tb_pix_collect;
    localparam int TW = 32;
    localparam int TH = 4;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pix_collect_if bus ();

    pix_collect #(.W(TW), .H(TH), .DEPTH(TD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [7:0] q[$];
    logic [7:0] acc;
    int         nbits;
    int         pidx;
    bit         m_ovf;
    bit         m_line;
    bit         m_frame;

    // drive one cycle of inputs, then advance the model to match the post-edge state
    task automatic step(input logic p, input logic v, input logic r, input logic rs);
        bit mpop;
        bus.pix    = p;
        bus.pvalid = v;
        bus.rdy    = r;
        rst        = rs;
        mpop = (q.size() > 0) && r;
        @(posedge clk);
        #1;
        if (rs) begin
            q.delete();
            acc = 8'h00; nbits = 0; pidx = 0;
            m_ovf = 0; m_line = 0; m_frame = 0;
        end else begin
            if (mpop) void'(q.pop_front());
            m_line  = v && (pidx % TW == TW - 1);
            m_frame = v && (pidx == TW * TH - 1);
            if (v) begin
                acc   = {acc[6:0], p};
                nbits = nbits + 1;
                pidx  = (pidx + 1) % (TW * TH);
                if (nbits == 8) begin
                    nbits = 0;
                    if (q.size() < TD) q.push_back(acc);
                    else m_ovf = 1;
                end
            end
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        checks += 5;
        if (bus.dvalid !== 1'b0)     begin failures++; $display("FAIL reset_dvalid got=%b exp=0", bus.dvalid); end
        if (bus.line_done !== 1'b0)  begin failures++; $display("FAIL reset_line_done got=%b exp=0", bus.line_done); end
        if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", bus.frame_done); end
        if (bus.overflow !== 1'b0)   begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
        if (bus.data !== 8'h00)      begin failures++; $display("FAIL reset_data got=%h exp=00", bus.data); end
    endtask

    task automatic test_basic();
        logic [7:0] pat;
        pat = 8'hB2;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            step(pat[i], 1'b1, 1'b1, 1'b0);
            if (i > 0) begin
                checks++;
                if (bus.dvalid !== 1'b0) begin failures++; $display("FAIL basic_early_dvalid bit=%0d got=%b exp=0", i, bus.dvalid); end
            end
        end
        checks += 2;
        if (bus.dvalid !== 1'b1) begin failures++; $display("FAIL basic_dvalid got=%b exp=1", bus.dvalid); end
        if (bus.data !== 8'hB2)  begin failures++; $display("FAIL basic_data got=%h exp=b2", bus.data); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks += 2;
        if (bus.dvalid !== 1'b0)   begin failures++; $display("FAIL basic_pulse got=%b exp=0", bus.dvalid); end
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL basic_overflow got=%b exp=0", bus.overflow); end
    endtask

    task automatic test_gapped();
        logic [7:0] pat;
        int hi;
        pat = 8'hB2;
        hi  = 0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            step(pat[i], 1'b1, 1'b1, 1'b0);
            if (bus.dvalid === 1'b1) begin
                hi++;
                checks++;
                if (bus.data !== 8'hB2) begin failures++; $display("FAIL gapped_data got=%h exp=b2", bus.data); end
            end
            step(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
            if (bus.dvalid === 1'b1) hi++;
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            if (bus.dvalid === 1'b1) hi++;
        end
        checks++;
        if (hi != 1) begin failures++; $display("FAIL gapped_byte_count got=%0d exp=1", hi); end
    endtask

    task automatic test_overflow();
        int popped;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 8 * (TD + 1); i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 8 * TD) begin
                checks += 2;
                if (bus.dvalid !== 1'b1) begin failures++; $display("FAIL ovf_full_dvalid got=%b exp=1", bus.dvalid); end
                if (bus.data !== 8'hFF)  begin failures++; $display("FAIL ovf_full_data got=%h exp=ff", bus.data); end
            end
            if (i == 8 * (TD + 1) - 1) begin
                checks++;
                if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", bus.overflow); end
            end
        end
        checks++;
        if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", bus.overflow); end
        popped = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.dvalid === 1'b1) begin
                popped++;
                checks++;
                if (bus.data !== 8'hFF) begin failures++; $display("FAIL ovf_drain_data got=%h exp=ff", bus.data); end
            end
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        checks += 2;
        if (popped != TD)          begin failures++; $display("FAIL ovf_drain_count got=%0d exp=%0d", popped, TD); end
        if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    endtask

    task automatic test_full_pop();
        int popped;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8 * TD + 7; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        step(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
        checks += 3;
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL fullpop_overflow got=%b exp=0", bus.overflow); end
        if (bus.dvalid !== 1'b1)   begin failures++; $display("FAIL fullpop_dvalid got=%b exp=1", bus.dvalid); end
        if (q.size() != TD)        begin failures++; $display("FAIL fullpop_model_count got=%0d exp=%0d", q.size(), TD); end
        popped = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.dvalid === 1'b1) begin
                popped++;
                checks++;
                if (q.size() == 0 || bus.data !== q[0]) begin
                    failures++; $display("FAIL fullpop_order got=%h exp=%h", bus.data, (q.size() > 0) ? q[0] : 8'hxx);
                end
            end
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        checks++;
        if (popped != TD) begin failures++; $display("FAIL fullpop_drain_count got=%0d exp=%0d", popped, TD); end
    endtask

    task automatic test_frame();
        int lines, frames, bytes;
        lines = 0; frames = 0; bytes = 0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 2 * TW * TH + 4; k++) begin
            if (bus.dvalid === 1'b1) bytes++;
            if (k < 2 * TW * TH) step(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
            else                 step(1'b0, 1'b0, 1'b1, 1'b0);
            if (bus.line_done === 1'b1)  lines++;
            if (bus.frame_done === 1'b1) frames++;
            checks += 4;
            if (bus.line_done !== m_line)   begin failures++; $display("FAIL frame_line k=%0d got=%b exp=%b", k, bus.line_done, m_line); end
            if (bus.frame_done !== m_frame) begin failures++; $display("FAIL frame_frame k=%0d got=%b exp=%b", k, bus.frame_done, m_frame); end
            if (bus.dvalid !== (q.size() > 0)) begin failures++; $display("FAIL frame_dvalid k=%0d got=%b exp=%b", k, bus.dvalid, q.size() > 0); end
            if (bus.overflow !== 1'b0)      begin failures++; $display("FAIL frame_overflow k=%0d got=%b exp=0", k, bus.overflow); end
            if (q.size() > 0) begin
                checks++;
                if (bus.data !== q[0]) begin failures++; $display("FAIL frame_data k=%0d got=%h exp=%h", k, bus.data, q[0]); end
            end
            if (k == TW * TH - 1 || k == 2 * TW * TH - 1) begin
                checks++;
                if (bus.frame_done !== 1'b1) begin failures++; $display("FAIL frame_done_pos k=%0d got=%b exp=1", k, bus.frame_done); end
            end
        end
        checks += 3;
        if (lines != 2 * TH)          begin failures++; $display("FAIL frame_line_count got=%0d exp=%0d", lines, 2 * TH); end
        if (frames != 2)              begin failures++; $display("FAIL frame_frame_count got=%0d exp=2", frames); end
        if (bytes != 2 * TW * TH / 8) begin failures++; $display("FAIL frame_byte_count got=%0d exp=%0d", bytes, 2 * TW * TH / 8); end
    endtask

    task automatic test_mid_reset();
        logic [7:0] pat;
        pat = 8'hAA;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 7; i >= 0; i--) step(pat[i], 1'b1, 1'b0, 1'b0);
        checks += 2;
        if (bus.dvalid !== 1'b1) begin failures++; $display("FAIL midrst_dvalid got=%b exp=1", bus.dvalid); end
        if (bus.data !== 8'hAA)  begin failures++; $display("FAIL midrst_data got=%h exp=aa", bus.data); end
        for (int j = 9; j <= TW; j++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            checks++;
            if (bus.line_done !== (j == TW)) begin failures++; $display("FAIL midrst_line pix=%0d got=%b exp=%b", j, bus.line_done, j == TW); end
        end
    endtask

    task automatic test_random();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 600; k++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) < 2), 1'($urandom_range(0, 199) == 0));
            checks += 4;
            if (bus.line_done !== m_line)   begin failures++; $display("FAIL rand_line k=%0d got=%b exp=%b", k, bus.line_done, m_line); end
            if (bus.frame_done !== m_frame) begin failures++; $display("FAIL rand_frame k=%0d got=%b exp=%b", k, bus.frame_done, m_frame); end
            if (bus.dvalid !== (q.size() > 0)) begin failures++; $display("FAIL rand_dvalid k=%0d got=%b exp=%b", k, bus.dvalid, q.size() > 0); end
            if (bus.overflow !== m_ovf)     begin failures++; $display("FAIL rand_overflow k=%0d got=%b exp=%b", k, bus.overflow, m_ovf); end
            if (q.size() > 0) begin
                checks++;
                if (bus.data !== q[0]) begin failures++; $display("FAIL rand_data k=%0d got=%h exp=%h", k, bus.data, q[0]); end
            end
        end
    endtask

    initial begin
        bus.pix = 1'b0; bus.pvalid = 1'b0; bus.rdy = 1'b0;
        acc = 8'h00; nbits = 0; pidx = 0; m_ovf = 0; m_line = 0; m_frame = 0;
        test_reset();
        test_basic();
        test_gapped();
        test_overflow();
        test_full_pop();
        test_frame();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pix_collect.md
# pix_collect

Output collector for the serial binary-morphology pipeline. It takes the one-bit processed pixel stream and its delayed valid marker (the pipeline's `bypass` output) and packs the pixels MSB-first into bytes. Completed bytes go into a small FIFO that a host drains over a valid/ready handshake. The block counts pixels in raster order and flags line ends, frame end and FIFO overflow.

## Interface
- `W`, 256: image width in pixels; must be a multiple of 8.
- `H`, 256: image height in lines.
- `DEPTH`, 4: FIFO depth in bytes; must be a power of two, at least 2.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `pix`  in  1  processed pixel from the morphology stage.
- `pvalid`  in  1  pixel qualifier (the pipeline's delayed valid marker); `pix` is accepted on any edge where `pvalid`=1.
- `rdy`  in  1  host ready to take `data`.
- `data`  out  8  FIFO head byte; its first received pixel is in bit 7.
- `dvalid`  out  1  FIFO not empty.
- `line_done`  out  1  one-cycle pulse after the last pixel of each line is accepted.
- `frame_done`  out  1  one-cycle pulse after the last pixel of the frame is accepted.
- `overflow`  out  1  sticky; set when a completed byte is dropped.

## Operation
- Pixel acceptance:
  - On an edge with `pvalid`=1, shift `pix` into an 8-bit packing register, MSB-first: `sh <= {sh[6:0], pix}`.
  - Increment `bit_cnt` (3 bits), `col` (0..W-1) and `row` (0..H-1).
  - `pvalid`=0 holds all counters and the packing register unchanged.
- Byte completion: when a pixel is accepted with `bit_cnt`=7, the byte `{sh[6:0], pix}` is pushed into the FIFO. `bit_cnt` wraps to 0.
- Column and row counting:
  - `col` wraps from W-1 to 0, which increments `row`.
  - When `row`=H-1 and `col`=W-1, both counters wrap to 0 and the next frame starts without any re-arm.
- FIFO:
  - Circular buffer with DEPTH entries, read/write pointers and an occupancy count from 0 to DEPTH.
  - Pop occurs when `dvalid`=1 and `rdy`=1.
  - `data` always shows the head entry. When empty, `data` is don't-care (the RTL holds the last value).
- Boundary conditions:
  - Push while full and no pop in the same cycle: the byte is dropped, `overflow` is set, and FIFO contents and pointers are unchanged.
  - Push while full with a pop in the same cycle: both take effect, count stays at DEPTH, and there is no overflow.
  - Push while empty: the byte is stored, and `dvalid` rises on the following cycle. There is no combinational bypass from input to output.
  - Pop while empty is ignored (it cannot happen, because a pop requires `dvalid`=1).
- Reset: when `rst`=1 at an edge, the following all return to zero on that edge:
  - `sh`, `bit_cnt`, `col`, `row`
  - FIFO pointers and count
  - `overflow`, `line_done`, `frame_done`

  This applies mid-byte and mid-frame: the partial byte is discarded. The first pixel accepted after reset is row 0, col 0, bit 7 of the next byte. `rst` overrides `pvalid` and `rdy` in the same cycle.

## Timing
- Reset values: `dvalid`=0, `line_done`=0, `frame_done`=0, `overflow`=0, `data`=8'h00.
- Byte latency: if the 8th pixel is accepted at edge t, `dvalid`=1 and `data` equals that byte from just after edge t. This is one cycle after the pixel is presented.
- `line_done` and `frame_done` are registered. Each is high for exactly the one cycle after the edge that accepted the last pixel of a line or frame. The last line's pulse coincides with `frame_done`.
- `overflow` is set on the edge of the dropped push and stays high until `rst`.
- Throughput: one pixel per cycle sustained. The host needs a pop at least every 8 cycles to avoid overflow.
- All outputs are driven directly from registers.

## Test plan
- Reset then 8 pixels 1,0,1,1,0,0,1,0 with `pvalid`=1 and `rdy`=1:
  - `dvalid` pulses for 1 cycle with `data`=8'hB2.
  - `overflow` stays 0.
- Gapped stream: the same 8 pixels with `pvalid` toggling 1,0 every cycle -> same byte 8'hB2; no extra bytes are produced.
- `rdy`=0, all-ones stream for 8·(DEPTH+1) pixels:
  - The first DEPTH bytes are held as 8'hFF.
  - `overflow` rises on the edge after the 40th pixel (with DEPTH=4).
  - Raising `rdy` then drains exactly 4 bytes.
- Full FIFO, a 5th byte completing in the same cycle as `rdy`=1 -> no overflow; count stays at 4; the byte order is preserved.
- Full W×H frame (256×256, 65536 pixels):
  - 256 `line_done` pulses and one `frame_done` pulse, the latter in the cycle after pixel 65536.
  - 8192 bytes delivered.
  - A second frame behaves identically.
- `rst` asserted after 3 pixels of a byte, then 8 pixels of alternating 1,0 starting with 1 -> a single byte 8'hAA; no stale bits; counters restart at row 0, col 0.
